// File: rtl/mmu_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mmu_read_arbiter
// Brief    : Arbitrates NUM_PORTS read masters onto one AXI AR/R channel pair.
//            Define MMU_ARB_ROUND_ROBIN_EN for round-robin, else fixed priority.
// Revision : 1.0 - initial release
// ============================================================================
module mmu_read_arbiter #(
  parameter int NUM_PORTS = 2,
  parameter int BURST_LEN = 16,
  parameter int ID_W      = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_PORTS-1:0]    req_valid,
  input  logic [NUM_PORTS*32-1:0] req_addr,
  input  logic [NUM_PORTS-1:0]    req_single,
  output logic [NUM_PORTS-1:0]    req_ready,
  output logic [31:0]             resp_data,
  output logic [NUM_PORTS-1:0]    resp_valid,
  output logic [NUM_PORTS-1:0]    resp_last,
  output logic [NUM_PORTS-1:0]    resp_err,
  output logic                    proto_err,
  output logic [ID_W-1:0]         arid,
  output logic [31:0]             araddr,
  output logic [7:0]              arlen,
  output logic [2:0]              arsize,
  output logic [1:0]              arburst,
  output logic                    arvalid,
  input  logic                    arready,
  input  logic [ID_W-1:0]         rid,
  input  logic [31:0]             rdata,
  input  logic [1:0]              rresp,
  input  logic                    rlast,
  input  logic                    rvalid,
  output logic                    rready
);

  localparam int       c_idx_w       = $clog2(NUM_PORTS);
  localparam bit [7:0] c_burst_arlen = 8'(BURST_LEN - 1);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_t;

  state_t             r_state;
  logic [c_idx_w-1:0] r_win;
  logic [7:0]         r_count;
`ifdef MMU_ARB_ROUND_ROBIN_EN
  logic [c_idx_w-1:0] r_ptr;
`endif

  logic               w_found;
  logic [c_idx_w-1:0] w_pick;
  logic [c_idx_w:0]   w_cand;
  logic [31:0]        w_addr;
  logic               w_rid_match;
  logic               w_beat;
  logic               w_bad_id;
  logic               w_len_err;
  logic               w_ar_done;

  // Winner search; the extra bit in w_cand absorbs the pointer wrap-around.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_cand  = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
`ifdef MMU_ARB_ROUND_ROBIN_EN
      w_cand = {1'b0, r_ptr} + (c_idx_w+1)'(k);
      if (w_cand >= (c_idx_w+1)'(NUM_PORTS))
        w_cand = w_cand - (c_idx_w+1)'(NUM_PORTS);
`else
      w_cand = (c_idx_w+1)'(k);
`endif
      if (!w_found && req_valid[w_cand[c_idx_w-1:0]]) begin
        w_found = 1'b1;
        w_pick  = w_cand[c_idx_w-1:0];
      end
    end
  end

  assign w_addr      = req_addr[32*w_pick +: 32];
  assign w_rid_match = (rid == ID_W'(r_win));
  assign w_beat      = (r_state == S_DATA) && rvalid && w_rid_match;
  assign w_bad_id    = (r_state == S_DATA) && rvalid && !w_rid_match;
  assign w_len_err   = w_beat && ((rlast && (r_count != arlen)) ||
                                  (!rlast && (r_count == arlen)));
  assign w_ar_done   = (r_state == S_ADDR) && arready;

  assign arid   = ID_W'(r_win);
  assign arsize = 3'b010;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_win     <= '0;
      r_count   <= '0;
      arvalid   <= 1'b0;
      rready    <= 1'b0;
      araddr    <= '0;
      arlen     <= '0;
      arburst   <= '0;
      proto_err <= 1'b0;
`ifdef MMU_ARB_ROUND_ROBIN_EN
      r_ptr     <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_state <= S_ADDR;
            r_win   <= w_pick;
            araddr  <= w_addr;
            arvalid <= 1'b1;
            if (req_single[w_pick]) begin
              arlen   <= 8'd0;
              arburst <= 2'b00;
            end else begin
              arlen   <= c_burst_arlen;
              arburst <= 2'b01;
            end
          end
        end
        S_ADDR: begin
          if (arready) begin
            r_state <= S_DATA;
            arvalid <= 1'b0;
            rready  <= 1'b1;
            r_count <= '0;
          end
        end
        S_DATA: begin
          if (w_beat) begin
            r_count <= r_count + 8'd1;
            if (rlast) begin
              r_state <= S_IDLE;
              rready  <= 1'b0;
`ifdef MMU_ARB_ROUND_ROBIN_EN
              r_ptr   <= (r_win == c_idx_w'(NUM_PORTS - 1)) ? '0 : r_win + 1'b1;
`endif
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
      if (w_bad_id || w_len_err)
        proto_err <= 1'b1;
    end
  end

  // Strobes are combinational so they coincide with the handshake / beat.
  always_comb begin
    req_ready  = '0;
    resp_valid = '0;
    resp_last  = '0;
    resp_err   = '0;
    resp_data  = '0;
    if (w_ar_done)
      req_ready[r_win] = 1'b1;
    if (w_beat) begin
      resp_data         = rdata;
      resp_valid[r_win] = 1'b1;
      resp_last[r_win]  = rlast;
      resp_err[r_win]   = |rresp;
    end
  end

endmodule
`default_nettype wire
